ram_param: RTL and testbench

Parametrised single-port synchronous RAM, successor to the fixed 8×8 `ram`. It generalises data width and depth, and replaces the tristate read port with a registered read and a `rd_valid` strobe. It adds a `ready` handshake, out-of-range address detection, and a multi-cycle sweep-clear engine. It sits between the control unit and the datapath as working memory, with a flattened debug tap replacing the per-word `memN` outputs.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_sweep.sv | 75 +++++++
 rtl/ram_param.sv | 123 ++++++++++++
 tb/tb_ram_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the parametrised RAM block.
//                ram_state_t is the sweep FSM state; RW_READ / RW_WRITE
//                encode the request-type input.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ram_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sweep
//  Description : Sweep-clear controller. An IDLE/SWEEP state machine plus the
//                index counter that walks the array from word 0 to DEPTH-1,
//                clearing one word per cycle.
//  Ports       : clk_i      - system clock
//                rst_ni     - asynchronous active-low reset
//                wipe_i     - start a sweep (only honoured in IDLE)
//                busy_o     - sweep in progress
//                clr_en_o   - clear the word at clr_idx_o on the next edge
//                clr_idx_o  - index of the word being cleared
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sweep #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wipe_i,
    output logic             busy_o,
    output logic             clr_en_o,
    output logic [IDX_W-1:0] clr_idx_o
);
    import ram_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    ram_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_o    = 1'b0;
        clr_en_o  = 1'b0;
        clr_idx_o = idx_q;
        case (state_q)
            IDLE: begin
                if (wipe_i) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                // wipe_i is deliberately ignored here: a sweep never restarts.
                busy_o   = 1'b1;
                clr_en_o = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule : ram_sweep
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : ram_param
//  Description : Parametrised single-port synchronous RAM with registered
//                read, read-valid strobe, ready handshake, out-of-range
//                detection and a multi-cycle sweep-clear engine.
//  Ports       : clk       - system clock
//                clr       - asynchronous active-low reset
//                enab      - request valid
//                rw        - 1 = write, 0 = read
//                Addr      - request word address
//                data_in   - write data
//                wipe      - start a sweep-clear of the whole array
//                ready     - request can be accepted this cycle
//                busy      - sweep-clear in progress
//                data_out  - registered read data (held between reads)
//                rd_valid  - data_out updated by a read this cycle
//                err       - last accepted request was out of range
//                mem_flat  - debug tap, word i at [i*DATA_W +: DATA_W]
//  Revision    : 1.0  initial release
// ============================================================================
module ram_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    enab,
    input  logic                    rw,
    input  logic [ADDR_W-1:0]       Addr,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    wipe,
    output logic                    ready,
    output logic                    busy,
    output logic [DATA_W-1:0]       data_out,
    output logic                    rd_valid,
    output logic                    err,
    output logic [DEPTH*DATA_W-1:0] mem_flat
);
    import ram_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    // DEPTH <= 2**ADDR_W, so one extra bit always holds DEPTH exactly.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_en;
    logic [IDX_W-1:0]  clr_idx;
    logic              accept;
    logic              in_range;
    logic              is_read;
    logic              wr_en;
    logic [IDX_W-1:0]  widx;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    ram_sweep #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sweep (
        .clk_i     (clk),
        .rst_ni    (clr),
        .wipe_i    (wipe),
        .busy_o    (busy),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx)
    );

    // wipe in IDLE wins over a simultaneous request.
    assign ready    = !busy && !wipe;
    assign accept   = enab && ready;
    assign in_range = {1'b0, Addr} < DEPTH_A;
    assign is_read  = (rw == RW_READ);
    assign wr_en    = accept && (rw == RW_WRITE) && in_range;
    // Only meaningful when in_range; upper Addr bits are covered by that check.
    assign widx     = Addr[IDX_W-1:0];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_word
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    mem_q[i] <= '0;
                end else if (clr_en && (clr_idx == IDX_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_en && (widx == IDX_W'(i))) begin
                    mem_q[i] <= data_in;
                end
            end
            assign mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
        end
    endgenerate

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = accept && is_read;
        err_d      = accept && !in_range;
        if (accept && is_read) begin
            data_out_d = in_range ? mem_q[widx] : '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule : ram_param
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_param
//  Description : Self-checking bench for ram_param. Instance A (8x8, 8-bit
//                address) runs directed sequences and random traffic against
//                a behavioural model compared every cycle; instance B
//                (16-bit x 32, 5-bit address) runs directed sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_param;

    localparam int DP = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;

    // Instance A
    logic        enab = 1'b0, rw = 1'b0, wipe = 1'b0;
    logic [7:0]  addr = '0, din = '0;
    logic        ready, busy, rd_valid, err;
    logic [7:0]  dout;
    logic [63:0] mflat;

    // Instance B
    logic         b_enab = 1'b0, b_rw = 1'b0, b_wipe = 1'b0;
    logic [4:0]   b_addr = '0;
    logic [15:0]  b_din = '0;
    logic         b_ready, b_busy, b_rdv, b_err;
    logic [15:0]  b_dout;
    logic [511:0] b_mflat;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_param #(.DATA_W(8), .DEPTH(8), .ADDR_W(8)) dut_a (
        .clk(clk), .clr(clr), .enab(enab), .rw(rw), .Addr(addr),
        .data_in(din), .wipe(wipe), .ready(ready), .busy(busy),
        .data_out(dout), .rd_valid(rd_valid), .err(err), .mem_flat(mflat)
    );

    ram_param #(.DATA_W(16), .DEPTH(32), .ADDR_W(5)) dut_b (
        .clk(clk), .clr(clr), .enab(b_enab), .rw(b_rw), .Addr(b_addr),
        .data_in(b_din), .wipe(b_wipe), .ready(b_ready), .busy(b_busy),
        .data_out(b_dout), .rd_valid(b_rdv), .err(b_err), .mem_flat(b_mflat)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model of instance A ----------------
    // A sweep is "words left to clear"; word (DP - left) is cleared each edge.
    logic [7:0] m_mem [DP];
    int         m_left;
    logic [7:0] m_dout;
    logic       m_rdv, m_err;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DP; i++) m_mem[i] <= '0;
            m_left <= 0;
            m_dout <= '0;
            m_rdv  <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_rdv <= 1'b0;
            m_err <= 1'b0;
            if (m_left > 0) begin
                m_mem[3'(DP - m_left)] <= '0;
                m_left <= m_left - 1;
            end else if (wipe) begin
                m_left <= DP;
            end else if (enab) begin
                if (int'(addr) >= DP) m_err <= 1'b1;
                if (rw == 1'b0) begin
                    m_rdv  <= 1'b1;
                    m_dout <= (int'(addr) < DP) ? m_mem[addr[2:0]] : 8'h00;
                end else if (int'(addr) < DP) begin
                    m_mem[addr[2:0]] <= din;
                end
            end
        end
    end

    function automatic logic [63:0] model_flat();
        logic [63:0] r;
        for (int i = 0; i < DP; i++) r[i*8 +: 8] = m_mem[i];
        return r;
    endfunction

    always @(negedge clk) begin
        chk("ready",    {511'd0, ready},    {511'd0, (m_left == 0) && !wipe});
        chk("busy",     {511'd0, busy},     {511'd0, m_left != 0});
        chk("data_out", {504'd0, dout},     {504'd0, m_dout});
        chk("rd_valid", {511'd0, rd_valid}, {511'd0, m_rdv});
        chk("err",      {511'd0, err},      {511'd0, m_err});
        chk("mem_flat", {448'd0, mflat},    {448'd0, model_flat()});
    end

    // ---------------- Stimulus helpers ----------------
    task automatic req(input logic r, input logic [7:0] a, input logic [7:0] d);
        enab = 1'b1; rw = r; addr = a; din = d;
        @(posedge clk); #1;
        enab = 1'b0;
    endtask

    task automatic breq(input logic r, input logic [4:0] a, input logic [15:0] d);
        b_enab = 1'b1; b_rw = r; b_addr = a; b_din = d;
        @(posedge clk); #1;
        b_enab = 1'b0;
    endtask

    initial begin
        int cnt;
        #2 clr = 1'b0;
        @(posedge clk); #1;
        chk("rst_dout",  {504'd0, dout},     512'h0);
        chk("rst_rdv",   {511'd0, rd_valid}, 512'h0);
        chk("rst_err",   {511'd0, err},      512'h0);
        chk("rst_busy",  {511'd0, busy},     512'h0);
        chk("rst_flat",  {448'd0, mflat},    512'h0);
        clr = 1'b1;
        chk("rst_ready", {511'd0, ready},    512'h1);
        @(posedge clk); #1;

        // Write then read back
        req(1'b1, 8'd3, 8'hA5);
        chk("wr3_flat", {504'd0, mflat[31:24]}, 512'hA5);
        chk("wr3_rdv",  {511'd0, rd_valid},     512'h0);
        req(1'b0, 8'd3, 8'h00);
        chk("rd3_dout", {504'd0, dout},     512'hA5);
        chk("rd3_rdv",  {511'd0, rd_valid}, 512'h1);
        @(posedge clk); #1;
        chk("rd3_rdv_drop", {511'd0, rd_valid}, 512'h0);
        chk("rd3_hold",     {504'd0, dout},     512'hA5);

        // Back-to-back reads
        req(1'b1, 8'd0, 8'h11);
        req(1'b1, 8'd7, 8'h22);
        req(1'b0, 8'd7, 8'h00);
        chk("b2b_d7", {504'd0, dout},     512'h22);
        chk("b2b_v7", {511'd0, rd_valid}, 512'h1);
        req(1'b0, 8'd0, 8'h00);
        chk("b2b_d0", {504'd0, dout},     512'h11);
        chk("b2b_v0", {511'd0, rd_valid}, 512'h1);

        // Out-of-range write and read
        req(1'b1, 8'd8, 8'hFF);
        chk("oor_wr_err",  {511'd0, err},   512'h1);
        chk("oor_wr_flat", {448'd0, mflat}, 512'h22000000A5000011);
        req(1'b0, 8'd200, 8'h00);
        chk("oor_rd_dout", {504'd0, dout},     512'h0);
        chk("oor_rd_rdv",  {511'd0, rd_valid}, 512'h1);
        chk("oor_rd_err",  {511'd0, err},      512'h1);

        // Fill, then wipe with a simultaneous request
        for (int k = 0; k < DP; k++) req(1'b1, 8'(k), 8'(k + 1));
        chk("fill_flat", {448'd0, mflat}, 512'h0807060504030201);
        wipe = 1'b1; enab = 1'b1; rw = 1'b1; addr = 8'd2; din = 8'h55;
        @(posedge clk); #1;
        wipe = 1'b0; enab = 1'b0;
        chk("swp_busy0",  {511'd0, busy},  512'h1);
        chk("swp_ready0", {511'd0, ready}, 512'h0);
        chk("swp_drop",   {504'd0, mflat[23:16]}, 512'h03);
        for (int k = 0; k < DP; k++) begin
            if (k == 2) wipe = 1'b1;
            @(posedge clk); #1;
            wipe = 1'b0;
            chk("swp_word_clr", {504'd0, mflat[k*8 +: 8]}, 512'h0);
            if (k < DP - 1)
                chk("swp_word_keep", {504'd0, mflat[(k+1)*8 +: 8]}, 512'(k + 2));
            chk("swp_busy",  {511'd0, busy},  512'(k < DP - 1));
            chk("swp_ready", {511'd0, ready}, 512'(k == DP - 1));
        end

        // Reset mid-sweep
        for (int k = 0; k < DP; k++) req(1'b1, 8'(k), 8'hC0 + 8'(k));
        req(1'b0, 8'd5, 8'h00);
        chk("pre_abort_dout", {504'd0, dout}, 512'hC5);
        wipe = 1'b1;
        @(posedge clk); #1;
        wipe = 1'b0;
        repeat (3) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        chk("abort_flat", {448'd0, mflat},    512'h0);
        chk("abort_dout", {504'd0, dout},     512'h0);
        chk("abort_busy", {511'd0, busy},     512'h0);
        chk("abort_rdv",  {511'd0, rd_valid}, 512'h0);
        chk("abort_err",  {511'd0, err},      512'h0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {511'd0, ready}, 512'h1);
        chk("abort_idle",  {511'd0, busy},  512'h0);

        // Instance B: wide/deep configuration
        breq(1'b1, 5'd31, 16'hBEEF);
        chk("b_flat31", {496'd0, b_mflat[511:496]}, 512'hBEEF);
        breq(1'b0, 5'd31, 16'h0000);
        chk("b_dout31", {496'd0, b_dout}, 512'hBEEF);
        chk("b_rdv31",  {511'd0, b_rdv},  512'h1);
        chk("b_err31",  {511'd0, b_err},  512'h0);
        breq(1'b1, 5'd0, 16'h1234);
        breq(1'b0, 5'd0, 16'h0000);
        chk("b_dout0", {496'd0, b_dout}, 512'h1234);
        chk("b_err0",  {511'd0, b_err},  512'h0);
        b_wipe = 1'b1;
        @(posedge clk); #1;
        b_wipe = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && b_busy; i++) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("b_busy_len", 512'(cnt), 512'd32);
        chk("b_wiped",    b_mflat,   512'h0);
        chk("b_ready",    {511'd0, b_ready}, 512'h1);

        // Random traffic on instance A, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (!clr) clr = 1'b1;
            enab = ($urandom_range(0, 3) != 0);
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 8));
            din  = 8'($urandom);
            wipe = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) clr = 1'b0;
        end
        @(posedge clk); #1;
        enab = 1'b0; wipe = 1'b0; clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram_param
`default_nettype wire
